adder: RTL and testbench
========================

ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter WIDTH, default 8: operand/sum width; SHALL be a multiple of 4 (bench exercises 8 only).
REQ-002 clk  input  1  sole clock; all registered state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high; sampled only on rising clk.
REQ-004 A  input  WIDTH  operand A, unsigned or two's complement.
REQ-005 B  input  WIDTH  operand B.
REQ-006 Cin  input  1  carry-in.
REQ-007 Sum  output  WIDTH  combinational sum, A+B+Cin mod 2^WIDTH.
REQ-008 Cout  output  1  combinational carry-out of MSB.
REQ-009 Sum_q  output  WIDTH  registered Sum.
REQ-010 Cout_q  output  1  registered Cout.
REQ-011 Ovf_q  output  1  registered signed overflow flag.
REQ-012 Zero_q  output  1  registered flag, Sum == 0.

Function
REQ-013 Sum/Cout SHALL be purely combinational from A, B, Cin: zero clock latency, independent of clk and rst.
REQ-014 {Cout,Sum} SHALL equal A+B+Cin exactly, as a WIDTH+1-bit unsigned result, for all 2^(2*WIDTH+1) input combinations.
REQ-015 Per-bit propagate p_i = A_i xor B_i, generate g_i = A_i and B_i; Sum_i = p_i xor c_i, c_0 = Cin.
REQ-016 Carries SHALL come from carry-lookahead logic: 4-bit blocks each computing internal carries plus group P/G, and a second-level lookahead unit producing block carry-ins and Cout; ripple-carry chains across bits are not permitted.
REQ-017 Overflow SHALL be computed as c_WIDTH xor c_(WIDTH-1) (carry into MSB xor carry out of MSB).
REQ-018 On each rising clk with rst=0: Sum_q<=Sum, Cout_q<=Cout, Ovf_q<=overflow, Zero_q<=(Sum==0); registered outputs lag inputs by exactly one cycle.
REQ-019 Registered outputs SHALL hold value between clock edges regardless of input changes.
REQ-020 Wrap-around: result exceeding 2^WIDTH-1 wraps mod 2^WIDTH with Cout=1; no saturation.
REQ-021 Cin=1 with A=B=all-ones yields Sum=all-ones, Cout=1 (maximum case).
REQ-022 Inputs with X/Z need not produce defined outputs; all defined inputs SHALL yield fully defined (no X) outputs.

Reset
REQ-023 rst=1 at a rising clk SHALL set Sum_q=0, Cout_q=0, Ovf_q=0, Zero_q=0 (Zero_q reset to 0, not 1, by decision).
REQ-024 rst has priority over capture; rst asserted mid-stream clears registers on that edge; first capture occurs on the first edge with rst=0.
REQ-025 rst SHALL NOT affect combinational Sum/Cout.

Verification
REQ-026 Comb vectors (check 10 ns after apply, no clock needed): 00+00,Cin0 -> 00,0; 01+00,0 -> 01,0; FF+FF,0 -> FE,1; FF+FF,1 -> FF,1; AA+55,0 -> FF,0; CC+33,1 -> 00,1.
REQ-027 Comb vectors: 80+80,0 -> 00,1; 00+00,1 -> 01,0; 55+AA,1 -> 00,1; F0+0F,0 -> FF,0; 0F+01,1 -> 11,0; 6B+25,0 -> 90,0.
REQ-028 Registered path: apply 80+80,Cin0, one clk edge -> Sum_q=00, Cout_q=1, Ovf_q=1, Zero_q=1; apply 7F+01,0, edge -> Sum_q=80, Cout_q=0, Ovf_q=1, Zero_q=0.
REQ-029 Reset: load FF+FF,1 (Sum_q=FF,Cout_q=1), assert rst one edge -> all registered outputs 0 while Sum=FF, Cout=1 remain; deassert -> next edge recaptures FF,1.
REQ-030 Exhaustive or ≥10000 random vectors (all Cin) compared against A+B+Cin reference model; comb outputs same cycle, registered outputs one cycle later.

Source files
------------

// File: rtl/adder.sv
// adder: WIDTH-bit two-level carry-lookahead adder with a registered copy of
// the result and status flags.
//
// Ports:
//   clk    - sole clock; all registered outputs update on its rising edge
//   rst    - synchronous active-high reset, clears the registered outputs only
//   A, B   - WIDTH-bit operands (unsigned or two's complement)
//   Cin    - carry-in
//   Sum    - combinational A+B+Cin mod 2^WIDTH
//   Cout   - combinational carry-out of the MSB
//   Sum_q  - Sum captured on the previous rising clk edge
//   Cout_q - Cout captured on the previous rising clk edge
//   Ovf_q  - signed overflow captured on the previous rising clk edge
//   Zero_q - (Sum == 0) captured on the previous rising clk edge
//
// WIDTH must be a multiple of 4: the carry tree is built from 4-bit
// lookahead blocks joined by a second-level lookahead unit.
module adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic [WIDTH-1:0] Sum_q,
    output logic             Cout_q,
    output logic             Ovf_q,
    output logic             Zero_q
);

    localparam int NB = WIDTH / 4;

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH:0]   c;
    logic [NB-1:0]    grp_p;
    logic [NB-1:0]    grp_g;
    logic [NB:0]      blk_c;
    logic             overflow;

    assign p = A ^ B;
    assign g = A & B;

    // Each 4-bit block derives its internal carries directly from its own
    // carry-in (flattened lookahead terms, no ripple) and reports group
    // propagate/generate to the second level.
    for (genvar k = 0; k < NB; k++) begin : g_blk
        logic [3:0] bp;
        logic [3:0] bg;
        logic       ci;

        assign bp = p[4*k +: 4];
        assign bg = g[4*k +: 4];
        assign ci = blk_c[k];

        assign c[4*k]   = ci;
        assign c[4*k+1] = bg[0] | (bp[0] & ci);
        assign c[4*k+2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & ci);
        assign c[4*k+3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
                        | (bp[2] & bp[1] & bp[0] & ci);

        assign grp_p[k] = &bp;
        assign grp_g[k] = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
                        | (bp[3] & bp[2] & bp[1] & bg[0]);
    end

    // Second-level lookahead: every block carry-in is an independent
    // sum-of-products over all lower group generates/propagates and Cin,
    // so no block waits on the carry of the block below it.
    always_comb begin
        logic term;
        logic acc;
        blk_c    = '0;
        blk_c[0] = Cin;
        for (int j = 1; j <= NB; j++) begin
            acc = 1'b0;
            for (int i = 0; i < j; i++) begin
                term = grp_g[i];
                for (int m = i + 1; m < j; m++) begin
                    term = term & grp_p[m];
                end
                acc = acc | term;
            end
            term = Cin;
            for (int m = 0; m < j; m++) begin
                term = term & grp_p[m];
            end
            blk_c[j] = acc | term;
        end
    end

    assign c[WIDTH] = blk_c[NB];

    assign Sum  = p ^ c[WIDTH-1:0];
    assign Cout = c[WIDTH];

    // Signed overflow: carry into the MSB differs from carry out of it.
    assign overflow = c[WIDTH] ^ c[WIDTH-1];

    // Result register; reset wins over capture and clears every flag,
    // including Zero_q, which therefore reads 0 straight after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            Sum_q  <= '0;
            Cout_q <= 1'b0;
            Ovf_q  <= 1'b0;
            Zero_q <= 1'b0;
        end else begin
            Sum_q  <= Sum;
            Cout_q <= Cout;
            Ovf_q  <= overflow;
            Zero_q <= (Sum == '0);
        end
    end

endmodule

// File: tb/tb_adder.sv
// tb_adder: self-checking bench for the 8-bit adder.
// Directed combinational vectors, registered-path and reset sequences, then
// randomized vectors compared against an arithmetic reference model.
module tb_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic [W-1:0] sum_q;
    logic         cout_q;
    logic         ovf_q;
    logic         zero_q;

    int checks   = 0;
    int failures = 0;

    adder #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .A      (a),
        .B      (b),
        .Cin    (cin),
        .Sum    (sum),
        .Cout   (cout),
        .Sum_q  (sum_q),
        .Cout_q (cout_q),
        .Ovf_q  (ovf_q),
        .Zero_q (zero_q)
    );

    // 10 ns clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } result_t;

    // Reference model from plain arithmetic: 9-bit unsigned sum, and signed
    // overflow from the operand/result sign rule.
    function automatic result_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic ci);
        result_t r;
        logic [W:0] full;
        int sx, sy, ss;
        full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        sx = $signed(x);
        sy = $signed(y);
        ss = sx + sy + int'(ci);
        r.ovf  = (ss > 127) || (ss < -128);
        r.zero = (r.sum == 0);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [W:0] observed,
                               input logic [W:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci);
        a   = x;
        b   = y;
        cin = ci;
    endtask

    task automatic checkComb(input string tag, input logic [W-1:0] es, input logic ec);
        checkOutput({tag, ".sum"},  {1'b0, sum},  {1'b0, es});
        checkOutput({tag, ".cout"}, {{W{1'b0}}, cout}, {{W{1'b0}}, ec});
    endtask

    task automatic checkRegs(input string tag, input result_t e);
        checkOutput({tag, ".sum_q"},  {1'b0, sum_q},  {1'b0, e.sum});
        checkOutput({tag, ".cout_q"}, {{W{1'b0}}, cout_q}, {{W{1'b0}}, e.cout});
        checkOutput({tag, ".ovf_q"},  {{W{1'b0}}, ovf_q},  {{W{1'b0}}, e.ovf});
        checkOutput({tag, ".zero_q"}, {{W{1'b0}}, zero_q}, {{W{1'b0}}, e.zero});
    endtask

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         ci;
        logic [W-1:0] es;
        logic         ec;
    } vec_t;

    vec_t vecs[12];
    result_t zero_res;
    result_t exp_r;
    result_t pending;

    initial begin
        vecs[0]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{8'h01, 8'h00, 1'b0, 8'h01, 1'b0};
        vecs[2]  = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
        vecs[3]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[5]  = '{8'hCC, 8'h33, 1'b1, 8'h00, 1'b1};
        vecs[6]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[7]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[8]  = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1};
        vecs[9]  = '{8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0};
        vecs[10] = '{8'h0F, 8'h01, 1'b1, 8'h11, 1'b0};
        vecs[11] = '{8'h6B, 8'h25, 1'b0, 8'h90, 1'b0};
        zero_res = '{8'h00, 1'b0, 1'b0, 1'b0};

        // Reset state
        rst = 1'b1;
        applyStimulus(8'h00, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkRegs("reset", zero_res);

        // Directed combinational vectors, checked 10 ns after apply
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].x, vecs[i].y, vecs[i].ci);
            #10;
            checkComb($sformatf("comb%0d", i), vecs[i].es, vecs[i].ec);
        end

        // Registered path with fixed expectations
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h80, 8'h80, 1'b0);
        @(posedge clk);
        #1;
        checkRegs("reg80p80", '{8'h00, 1'b1, 1'b1, 1'b1});
        @(negedge clk);
        applyStimulus(8'h7F, 8'h01, 1'b0);
        @(posedge clk);
        #1;
        checkRegs("reg7Fp01", '{8'h80, 1'b0, 1'b1, 1'b0});

        // Registers hold between edges while inputs move
        applyStimulus(8'h12, 8'h34, 1'b1);
        #2;
        checkRegs("hold", '{8'h80, 1'b0, 1'b1, 1'b0});
        checkComb("hold_comb", 8'h47, 1'b0);

        // Reset clears registers but not the combinational sum
        @(negedge clk);
        applyStimulus(8'hFF, 8'hFF, 1'b1);
        @(posedge clk);
        #1;
        checkRegs("loadFF", '{8'hFF, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkRegs("midreset", zero_res);
        checkComb("midreset_comb", 8'hFF, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkRegs("recapture", '{8'hFF, 1'b1, 1'b0, 1'b0});

        // Randomized vectors with occasional reset pulses
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            applyStimulus(W'($urandom), W'($urandom), 1'($urandom));
            rst = ($urandom_range(0, 49) == 0);
            exp_r   = model(a, b, cin);
            pending = rst ? zero_res : exp_r;
            #1;
            checkComb("rand_comb", exp_r.sum, exp_r.cout);
            @(posedge clk);
            #1;
            checkRegs("rand_reg", pending);
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
